// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding,
// cascade-flag type and reset value, and operand-length limits.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Cascade flags: less-than, equal, greater-than (exactly one set when valid).
    typedef struct packed {
        logic l;
        logic e;
        logic g;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{l: 1'b0, e: 1'b1, g: 1'b0};

    localparam int NUM_BYTES_MIN = 1;
    localparam int NUM_BYTES_MAX = 16;

    // Byte-counter width; a 1-byte operand still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comparator_8bits.sv
// 8-bit magnitude comparator with cascade inputs: a differing byte decides the
// result, an equal byte forwards the lower-significance cascade flags.
module comparator_8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       l_in,
    input  logic       e_in,
    input  logic       g_in,
    output logic       l_out,
    output logic       e_out,
    output logic       g_out
);

    always_comb begin
        l_out = l_in;
        e_out = e_in;
        g_out = g_in;
        if (a > b) begin
            l_out = 1'b0;
            e_out = 1'b0;
            g_out = 1'b1;
        end else if (a < b) begin
            l_out = 1'b1;
            e_out = 1'b0;
            g_out = 1'b0;
        end
    end

endmodule

// File: rtl/serial_comparator.sv
// Compares two NUM_BYTES-wide operands streamed LSB byte first, folding each
// byte into registered cascade flags and presenting lt/eq/gt with a handshake.
module serial_comparator
    import cmp_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       lt,
    output logic       eq,
    output logic       gt,
    output logic       busy
);

    localparam int CW = cnt_width(NUM_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    flags_t          flags_reg, flags_next;
    flags_t          cmp_flags;
    logic            accept;

    comparator_8bits u_cmp (
        .a     (a_byte),
        .b     (b_byte),
        .l_in  (flags_reg.l),
        .e_in  (flags_reg.e),
        .g_in  (flags_reg.g),
        .l_out (cmp_flags.l),
        .e_out (cmp_flags.e),
        .g_out (cmp_flags.g)
    );

    assign accept = in_valid && (state_reg == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            flags_reg <= FLAGS_RESET;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            flags_reg <= flags_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        flags_next = flags_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    count_next = '0;
                    flags_next = FLAGS_RESET;
                end
            end
            RUN: begin
                if (accept) begin
                    flags_next = cmp_flags;
                    count_next = count_reg + 1'b1;
                    if (count_reg == LAST_IDX) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even alongside result_ready.
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready     = (state_reg == RUN);
        busy         = (state_reg != IDLE);
        result_valid = (state_reg == DONE);
        lt           = result_valid && flags_reg.l;
        eq           = result_valid && flags_reg.e;
        gt           = result_valid && flags_reg.g;
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator: a 4-byte instance exercising all
// handshake and reset cases, plus a 1-byte instance for the single-byte case.
module tb_serial_comparator;

    logic       clk;
    logic       rst;
    logic       start, in_valid, result_ready;
    logic [7:0] a_byte, b_byte;
    logic       in_ready, result_valid, lt, eq, gt, busy;

    logic       start1, in_valid1, result_ready1;
    logic [7:0] a_byte1, b_byte1;
    logic       in_ready1, result_valid1, lt1, eq1, gt1, busy1;

    int checks = 0;
    int errors = 0;

    serial_comparator #(.NUM_BYTES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_byte       (a_byte),
        .b_byte       (b_byte),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .lt           (lt),
        .eq           (eq),
        .gt           (gt),
        .busy         (busy)
    );

    serial_comparator #(.NUM_BYTES(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .start        (start1),
        .in_valid     (in_valid1),
        .in_ready     (in_ready1),
        .a_byte       (a_byte1),
        .b_byte       (b_byte1),
        .result_valid (result_valid1),
        .result_ready (result_ready1),
        .lt           (lt1),
        .eq           (eq1),
        .gt           (gt1),
        .busy         (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {busy, in_ready, result_valid, lt, eq, gt} for compact status checks.
    function automatic logic [7:0] status();
        return {2'b00, busy, in_ready, result_valid, lt, eq, gt};
    endfunction

    task automatic send_byte(input string tag, input logic [7:0] a, input logic [7:0] b);
        a_byte   = a;
        b_byte   = b;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, {7'd0, in_ready}, 8'd1);
        @(negedge clk);
        in_valid = 1'b0;
        $display("txn %s: a=%02h b=%02h", tag, a, b);
    endtask

    task automatic begin_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 0; in_valid = 0; result_ready = 0; a_byte = 0; b_byte = 0;
        start1 = 0; in_valid1 = 0; result_ready1 = 0; a_byte1 = 0; b_byte1 = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset_status", status(), 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("idle_status", status(), 8'h00);

        // Equal operands 0x12345678, continuous in_valid.
        begin_run();
        check("eq_run_status", status(), 8'h30);
        send_byte("eq_b0", 8'h78, 8'h78);
        send_byte("eq_b1", 8'h56, 8'h56);
        send_byte("eq_b2", 8'h34, 8'h34);
        check("eq_not_yet_valid", status(), 8'h30);
        send_byte("eq_b3", 8'h12, 8'h12);
        check("eq_result", status(), 8'h2A);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("eq_back_idle", status(), 8'h00);

        // MSB decides: 0x01000000 vs 0x00FFFFFF.
        begin_run();
        send_byte("msb_b0", 8'h00, 8'hFF);
        send_byte("msb_b1", 8'h00, 8'hFF);
        send_byte("msb_b2", 8'h00, 8'hFF);
        send_byte("msb_b3", 8'h01, 8'h00);
        check("msb_gt", status(), 8'h29);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;

        // LSB decides with 2-cycle gaps: 0x12345677 vs 0x12345678.
        begin_run();
        send_byte("gap_b0", 8'h77, 8'h78);
        repeat (2) begin
            @(negedge clk);
            check("gap_hold0", status(), 8'h30);
        end
        send_byte("gap_b1", 8'h56, 8'h56);
        repeat (2) begin
            @(negedge clk);
            check("gap_hold1", status(), 8'h30);
        end
        send_byte("gap_b2", 8'h34, 8'h34);
        repeat (2) begin
            @(negedge clk);
            check("gap_hold2", status(), 8'h30);
        end
        send_byte("gap_b3", 8'h12, 8'h12);
        check("gap_lt", status(), 8'h2C);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;

        // Backpressure on result: 0x00000002 vs 0x00000001, start poked during DONE.
        begin_run();
        send_byte("bp_b0", 8'h02, 8'h01);
        send_byte("bp_b1", 8'h00, 8'h00);
        send_byte("bp_b2", 8'h00, 8'h00);
        send_byte("bp_b3", 8'h00, 8'h00);
        check("bp_gt", status(), 8'h29);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            @(negedge clk);
            check("bp_hold", status(), 8'h29);
        end
        start = 1'b1;
        result_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_not_restarted", status(), 8'h00);
        start = 1'b0;
        result_ready = 1'b0;
        @(negedge clk);
        check("bp_still_idle", status(), 8'h00);

        // Asynchronous reset mid-run, then a clean 0xFF000000 vs 0x00000001.
        begin_run();
        send_byte("rst_b0", 8'h00, 8'h05);
        send_byte("rst_b1", 8'h00, 8'h00);
        #2 rst = 1'b1;
        #1 check("rst_async", status(), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle_after", status(), 8'h00);
        begin_run();
        send_byte("post_b0", 8'h00, 8'h01);
        send_byte("post_b1", 8'h00, 8'h00);
        send_byte("post_b2", 8'h00, 8'h00);
        send_byte("post_b3", 8'hFF, 8'h00);
        check("post_gt", status(), 8'h29);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;

        // Single-byte instance: 0x80 vs 0x7F.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("nb1_in_ready", {7'd0, in_ready1}, 8'd1);
        check("nb1_not_valid", {7'd0, result_valid1}, 8'd0);
        a_byte1 = 8'h80;
        b_byte1 = 8'h7F;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        $display("txn nb1: a=80 b=7f");
        check("nb1_result", {2'b00, busy1, in_ready1, result_valid1, lt1, eq1, gt1}, 8'h29);
        result_ready1 = 1'b1;
        @(negedge clk);
        result_ready1 = 1'b0;
        check("nb1_idle", {7'd0, busy1}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
